mem_stage: RTL and testbench

- Memory stage sitting directly downstream of the execute stage.
- Consumes the 16-bit ALU result as either a pass-through writeback value or a load/store address.
- Runs a request/done handshake with a multi-cycle data memory and stalls upstream while an access is outstanding.
- Produces a registered writeback value, a valid pulse and an error flag for the writeback stage, and latches HALT.

---
 rtl/mem_stage.sv | 136 +++++++++++++
 tb/tb_mem_stage.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: memory stage between execute and writeback.
//   Non-memory ops pass alu_out through with one cycle of latency. Legal
//   loads/stores issue a one-cycle mem_req and then wait in BUSY for mem_done,
//   holding stall high. The wait is bounded by TIMEOUT cycles. HALT parks the
//   stage in HALTED until rst.
// Ports:
//   clk, rst              clock, async active-high reset
//   valid_in, alu_out,    instruction from execute (alu_out = address or
//   store_data, mem_read, result)
//   mem_write, halt
//   mem_req/wr/addr/wdata request to data memory (addr/wdata/wr held in BUSY)
//   mem_rdata/done/err    response from data memory
//   stall                 combinational backpressure to upstream
//   valid_out, wb_data,   registered result to writeback (err is qualified
//   err                   by valid_out)
//   halted                sticky halt flag
module mem_stage #(
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [DATA_W-1:0] store_data,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              halt,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_done,
  input  logic              mem_err,
  output logic              stall,
  output logic              valid_out,
  output logic [DATA_W-1:0] wb_data,
  output logic              err,
  output logic              halted
);

  typedef enum logic [1:0] {IDLE, BUSY, HALTED} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             accept, is_mem, bad_op, go_mem, timeout;

  always_comb begin
    accept  = (state == IDLE) && valid_in;
    is_mem  = mem_read | mem_write;
    // Conflicting flags or an odd address make the access illegal.
    bad_op  = (mem_read & mem_write) | alu_out[0];
    go_mem  = accept && !halt && is_mem && !bad_op;
    // Fires in the TIMEOUT-th BUSY cycle (cnt is 0 in the first one);
    // a done in that same cycle takes priority.
    timeout = (state == BUSY) && !mem_done && (cnt == CNT_W'(TIMEOUT - 1));
    stall   = go_mem || (state != IDLE);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept && halt)  state_nxt = HALTED;
        else if (go_mem)     state_nxt = BUSY;
      end
      BUSY:   if (mem_done || timeout) state_nxt = IDLE;
      HALTED: state_nxt = HALTED;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      mem_req   <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      valid_out <= 1'b0;
      wb_data   <= '0;
      err       <= 1'b0;
      halted    <= 1'b0;
    end else begin
      mem_req   <= 1'b0;
      valid_out <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (halt) begin
              valid_out <= 1'b1;
              wb_data   <= '0;
              err       <= 1'b0;
              halted    <= 1'b1;
            end else if (is_mem && bad_op) begin
              valid_out <= 1'b1;
              wb_data   <= '0;
              err       <= 1'b1;
            end else if (is_mem) begin
              mem_req   <= 1'b1;
              mem_wr    <= mem_write;
              mem_addr  <= alu_out;
              mem_wdata <= store_data;
              cnt       <= '0;
            end else begin
              valid_out <= 1'b1;
              wb_data   <= alu_out;
              err       <= 1'b0;
            end
          end
        end
        BUSY: begin
          cnt <= cnt + CNT_W'(1);
          if (mem_done) begin
            valid_out <= 1'b1;
            err       <= mem_err;
            wb_data   <= mem_wr ? '0 : mem_rdata;
          end else if (timeout) begin
            valid_out <= 1'b1;
            err       <= 1'b1;
            wb_data   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  logic        clk, rst;
  logic        valid_in, mem_read, mem_write, halt;
  logic [15:0] alu_out, store_data;
  logic        mem_req, mem_wr;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_done, mem_err;
  logic        stall, valid_out, err, halted;
  logic [15:0] wb_data;

  int total = 0;
  int bad   = 0;

  mem_stage #(.DATA_W(16), .TIMEOUT(15), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .alu_out(alu_out),
    .store_data(store_data), .mem_read(mem_read), .mem_write(mem_write),
    .halt(halt), .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
    .mem_err(mem_err), .stall(stall), .valid_out(valid_out),
    .wb_data(wb_data), .err(err), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic clr_in();
    valid_in = 0; alu_out = 0; store_data = 0; mem_read = 0; mem_write = 0;
    halt = 0; mem_rdata = 0; mem_done = 0; mem_err = 0;
  endtask

  // Entered and left at a negedge. lat = BUSY cycle index (0 = the mem_req
  // cycle) in which mem_done is driven; -1 = never. exp_wait = BUSY cycles
  // spent before valid_out appears.
  task automatic mem_op(input logic [15:0] a, input logic [15:0] wd,
                        input logic rd, input logic wr, input int lat,
                        input logic merr, input logic [15:0] rdata,
                        input logic [15:0] exp_wb, input logic exp_err,
                        input int exp_wait);
    int n;
    valid_in = 1; alu_out = a; store_data = wd; mem_read = rd; mem_write = wr;
    #1 chk("acc_stall", stall, 1);
    @(negedge clk);
    clr_in();
    chk("req", mem_req, 1);
    chk("addr", mem_addr, a);
    chk("wr", mem_wr, wr);
    chk("wdata", mem_wdata, wd);
    n = 0;
    while (!valid_out && n < 40) begin
      if (n > 0) chk("req_once", mem_req, 0);
      if (n == lat) begin mem_done = 1; mem_err = merr; mem_rdata = rdata; end
      #1 chk("busy_stall", stall, 1);
      @(negedge clk);
      mem_done = 0; mem_err = 0; mem_rdata = 0;
      n++;
    end
    chk("wait_cycles", 16'(n), 16'(exp_wait));
    chk("mem_valid", valid_out, 1);
    chk("mem_wb", wb_data, exp_wb);
    chk("mem_err", err, exp_err);
    chk("post_stall", stall, 0);
  endtask

  typedef struct {
    logic vin; logic [15:0] alu; logic rd, wr, done;
    logic ev; logic [15:0] ewb; logic eerr;
  } vec_t;

  vec_t tv[8];

  initial begin
    tv[0] = '{1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1234, 1'b0}; // pass-through
    tv[1] = '{1'b1, 16'h0041, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1}; // misaligned load
    tv[2] = '{1'b1, 16'h0040, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b1}; // rd and wr
    tv[3] = '{1'b1, 16'h0013, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b1}; // misaligned store
    tv[4] = '{1'b0, 16'h5555, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1}; // idle: hold
    tv[5] = '{1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b0}; // pass-through
    tv[6] = '{1'b1, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b0}; // odd non-mem ok
    tv[7] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0001, 1'b0}; // stray done

    clr_in();
    rst = 1;
    #1;
    chk("rst_valid", valid_out, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_wr", mem_wr, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_wb", wb_data, 0);
    chk("rst_err", err, 0);
    chk("rst_halted", halted, 0);
    chk("rst_stall", stall, 0);
    @(negedge clk); @(negedge clk);
    rst = 0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      valid_in = tv[i].vin; alu_out = tv[i].alu; mem_read = tv[i].rd;
      mem_write = tv[i].wr; mem_done = tv[i].done; mem_rdata = 16'hDEAD;
      #1 chk($sformatf("v%0d_stall", i), stall, 0);
      @(negedge clk);
      chk($sformatf("v%0d_valid", i), valid_out, tv[i].ev);
      chk($sformatf("v%0d_wb", i), wb_data, tv[i].ewb);
      chk($sformatf("v%0d_err", i), err, tv[i].eerr);
      chk($sformatf("v%0d_req", i), mem_req, 0);
    end
    clr_in();

    // load, done 3 cycles after the request
    mem_op(16'h0040, 16'h0000, 1, 0, 3, 0, 16'hBEEF, 16'hBEEF, 0, 4);
    // store, 1-cycle memory
    mem_op(16'h0010, 16'hA5A5, 0, 1, 0, 0, 16'h7777, 16'h0000, 0, 1);
    // load completing with mem_err
    mem_op(16'h0020, 16'h0000, 1, 0, 2, 1, 16'h1234, 16'h1234, 1, 3);
    // never done: abort after 15 BUSY cycles
    mem_op(16'h0030, 16'h0000, 1, 0, -1, 0, 16'h0000, 16'h0000, 1, 15);
    // done exactly in the timeout cycle: done wins
    mem_op(16'h0032, 16'h0000, 1, 0, 14, 0, 16'h4321, 16'h4321, 0, 15);

    // reset in the 2nd BUSY cycle, then a stray done
    valid_in = 1; alu_out = 16'h0050; mem_read = 1;
    @(negedge clk);
    clr_in();
    chk("rb_req", mem_req, 1);
    @(negedge clk);
    #2 rst = 1;
    #1;
    chk("rb_req0", mem_req, 0);
    chk("rb_addr0", mem_addr, 0);
    chk("rb_wb0", wb_data, 0);
    chk("rb_stall0", stall, 0);
    chk("rb_valid0", valid_out, 0);
    @(negedge clk);
    rst = 0;
    mem_done = 1; mem_rdata = 16'h9999;
    @(negedge clk);
    mem_done = 0;
    chk("rb_stray_valid", valid_out, 0);
    chk("rb_stray_wb", wb_data, 0);
    @(negedge clk);
    chk("rb_stray_valid2", valid_out, 0);

    // leave a nonzero wb_data before halting
    valid_in = 1; alu_out = 16'h00AA;
    @(negedge clk);
    chk("pre_halt_wb", wb_data, 16'h00AA);

    // HALT, then loads that must be ignored
    halt = 1; alu_out = 16'h0040; mem_read = 1;
    @(negedge clk);
    halt = 0;
    chk("h_valid", valid_out, 1);
    chk("h_wb", wb_data, 0);
    chk("h_err", err, 0);
    chk("h_halted", halted, 1);
    #1 chk("h_stall", stall, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("h_req", mem_req, 0);
      chk("h_valid_off", valid_out, 0);
      chk("h_stall_k", stall, 1);
      chk("h_halted_k", halted, 1);
    end
    clr_in();
    #2 rst = 1;
    #1;
    chk("h_rst_halted", halted, 0);
    chk("h_rst_stall", stall, 0);
    @(negedge clk);
    rst = 0;
    valid_in = 1; alu_out = 16'h0F0F;
    @(negedge clk);
    clr_in();
    chk("post_rst_valid", valid_out, 1);
    chk("post_rst_wb", wb_data, 16'h0F0F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
